fp_status_monitor: RTL

Synthesizable checker that sits on the result side of `fp_mult_top`. It aligns each issued operand pair with the `z`/`status` the multiplier returns `LATENCY` cycles later, and checks status-flag consistency and flag-versus-result encoding rules. It counts checked and failing results and raises a sticky error with a first-failure code. It is the hardware receiving end for the multiplier's output interface, usable on FPGA bring-up as well as in simulation.

---
 rtl/fp_status_monitor.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/fp_status_monitor.sv
// Result-side checker for fp_mult_top: delays operands by LATENCY, checks status/result rules, counts and latches the first failure.
// Define FP_STATUS_MON_CAPTURE_EN to build the first-failure data capture (err_a/err_b/err_z/err_status).
module fp_status_monitor #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic [31:0]      z,
  input  logic [7:0]       status,
  output logic [CNT_W-1:0] checked_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err,
  output logic [3:0]       err_code,
  output logic [31:0]      err_a,
  output logic [31:0]      err_b,
  output logic [31:0]      err_z,
  output logic [7:0]       err_status
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAULT} state_e;

  state_e state_q, state_d;

  logic [LATENCY-1:0]       vld_q, vld_d;
  logic [LATENCY-1:0][31:0] da_q, da_d, db_q, db_d;
  logic [LATENCY:0]         vld_sh;
  logic [LATENCY:0][31:0]   da_sh, db_sh;

  logic [CNT_W-1:0] checked_q, checked_d, errc_q, errc_d;
  logic [3:0]       code_q, code_d;

  logic        slot_v;
  logic [31:0] slot_a, slot_b;
  logic [7:0]  ea, eb, ez;
  logic [22:0] mz;
  logic        f_zero, f_inf, f_inv, f_tiny, f_huge, f_inex;
  logic [12:0] viol;
  logic [3:0]  code_c;
  logic        found;
  logic        fail;
  logic        capture;

  // Shift by concatenating the new entry below the old stages and dropping the oldest.
  always_comb begin
    vld_sh = {vld_q, in_valid};
    da_sh  = {da_q, a};
    db_sh  = {db_q, b};
    vld_d  = clr ? '0 : vld_sh[LATENCY-1:0];
    da_d   = da_sh[LATENCY-1:0];
    db_d   = db_sh[LATENCY-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      da_q  <= '0;
      db_q  <= '0;
    end else begin
      vld_q <= vld_d;
      da_q  <= da_d;
      db_q  <= db_d;
    end
  end

  assign slot_v = vld_q[LATENCY-1];
  assign slot_a = da_q[LATENCY-1];
  assign slot_b = db_q[LATENCY-1];

  always_comb begin
    ea     = slot_a[30:23];
    eb     = slot_b[30:23];
    ez     = z[30:23];
    mz     = z[22:0];
    f_zero = status[0];
    f_inf  = status[1];
    f_inv  = status[2];
    f_tiny = status[3];
    f_huge = status[4];
    f_inex = status[5];

    viol     = '0;
    viol[0]  = f_zero & f_inf;
    viol[1]  = f_zero & f_inv;
    viol[2]  = f_zero & f_huge;
    viol[3]  = f_tiny & f_inv;
    viol[4]  = f_huge & f_inv;
    viol[5]  = f_inex & f_inv;
    viol[6]  = f_inf & f_tiny;
    viol[7]  = f_tiny & f_huge;
    viol[8]  = f_zero & (ez != 8'h00);
    viol[9]  = f_inf & (ez != 8'hFF);
    viol[10] = f_inv & !((ea == 8'h00 && eb == 8'hFF) || (ea == 8'hFF && eb == 8'h00));
    viol[11] = f_huge & !(ez == 8'hFF || (ez == 8'hFE && mz == '1));
    viol[12] = f_tiny & !(ez == 8'h00 || (ez == 8'h01 && mz == '0));

    code_c = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < 13; i++) begin
      if (viol[i] && !found) begin
        code_c = 4'(i);
        found  = 1'b1;
      end
    end
    fail = slot_v & found;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (slot_v) state_d = fail ? S_FAULT : S_RUN;
      S_RUN:   if (fail) state_d = S_FAULT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    if (clr) state_d = S_IDLE;
  end

  // A failing slot seen in IDLE is captured too, since it is checked in that same cycle.
  always_comb begin
    capture = 1'b0;
    err     = 1'b0;
    case (state_q)
      S_IDLE, S_RUN: capture = fail & !clr;
      S_FAULT:       err     = 1'b1;
      default:       ;
    endcase
  end

  always_comb begin
    checked_d = checked_q;
    errc_d    = errc_q;
    code_d    = code_q;
    if (clr) begin
      checked_d = '0;
      errc_d    = '0;
      code_d    = '0;
    end else begin
      if (slot_v && checked_q != '1) checked_d = checked_q + CNT_W'(1);
      if (fail && errc_q != '1)      errc_d    = errc_q + CNT_W'(1);
      if (capture)                   code_d    = code_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checked_q <= '0;
      errc_q    <= '0;
      code_q    <= '0;
    end else begin
      checked_q <= checked_d;
      errc_q    <= errc_d;
      code_q    <= code_d;
    end
  end

  assign checked_cnt = checked_q;
  assign err_cnt     = errc_q;
  assign err_code    = code_q;

`ifdef FP_STATUS_MON_CAPTURE_EN
  logic [31:0] cap_a_q, cap_b_q, cap_z_q;
  logic [7:0]  cap_s_q;
  logic [1:0]  unused_status;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_a_q <= '0;
      cap_b_q <= '0;
      cap_z_q <= '0;
      cap_s_q <= '0;
    end else if (clr) begin
      cap_a_q <= '0;
      cap_b_q <= '0;
      cap_z_q <= '0;
      cap_s_q <= '0;
    end else if (capture) begin
      cap_a_q <= slot_a;
      cap_b_q <= slot_b;
      cap_z_q <= z;
      cap_s_q <= status;
    end
  end

  assign err_a         = cap_a_q;
  assign err_b         = cap_b_q;
  assign err_z         = cap_z_q;
  assign err_status    = cap_s_q;
  assign unused_status = status[7:6];
`else
  logic unused_bits;

  assign err_a       = '0;
  assign err_b       = '0;
  assign err_z       = '0;
  assign err_status  = '0;
  assign unused_bits = ^{status[7:6], slot_a[31], slot_a[22:0], slot_b[31], slot_b[22:0]};
`endif

endmodule
